// File: rtl/cle_label_reader.sv
// Label SRAM read-back: packs the 1024-word label map into a 1-bit mask byte stream
// with foreground count / max label stats. Optional CRC-8 output via CLE_READER_CRC_EN.
module cle_label_reader #(
  parameter logic [9:0] BASE_ADDR = 10'd0,
  parameter int         NBYTES    = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  sram_q,
  output logic [9:0]  sram_a,
  output logic        sram_wen,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [10:0] fg_count,
  output logic [7:0]  max_label
`ifdef CLE_READER_CRC_EN
  ,
  output logic [7:0]  crc
`endif
);

  // state  | meaning
  // IDLE   | waiting for start; stats hold
  // FETCH  | present 8 addresses, shift in previous cycle's word
  // LAST   | capture 8th word, load output byte
  // EMIT   | hold byte until out_ready
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_EMIT, S_DONE} state_t;

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  state_t         state_q, state_d;
  logic [9:0]     addr_q, addr_d;
  logic [2:0]     phase_q, phase_d;
  logic [CW-1:0]  byte_q, byte_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic [10:0]    fg_q, fg_d;
  logic [7:0]     max_q, max_d;
  logic           sample;
  logic           capture;

`ifdef CLE_READER_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`endif

  // The word presented last cycle arrives now; phase 0 has no prior word of this byte.
  assign sample  = (sram_q != 8'd0);
  assign capture = ((state_q == S_FETCH) && (phase_q != 3'd0)) || (state_q == S_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fg_d    = fg_q;
    max_d   = max_q;
`ifdef CLE_READER_CRC_EN
    crc_d   = crc_q;
`endif

    if (capture) begin
      shift_d = {shift_q[6:0], sample};
      fg_d    = fg_q + 11'(sample);
      if (sram_q > max_q) max_d = sram_q;
`ifdef CLE_READER_CRC_EN
      crc_d   = crc8_step(crc_q, sram_q);
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = BASE_ADDR;
          phase_d = 3'd0;
          byte_d  = '0;
          fg_d    = 11'd0;
          max_d   = 8'd0;
`ifdef CLE_READER_CRC_EN
          crc_d   = 8'd0;
`endif
        end
      end
      S_FETCH: begin
        addr_d  = addr_q + 10'd1;
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd7) state_d = S_LAST;
      end
      S_LAST: begin
        data_d  = {shift_q[6:0], sample};
        valid_d = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (byte_q == LAST_BYTE) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      phase_q <= 3'd0;
      byte_q  <= '0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      fg_q    <= 11'd0;
      max_q   <= 8'd0;
`ifdef CLE_READER_CRC_EN
      crc_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fg_q    <= fg_d;
      max_q   <= max_d;
`ifdef CLE_READER_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign sram_a    = addr_q;
  assign sram_wen  = 1'b1;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_LAST) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
  assign fg_count  = fg_q;
  assign max_label = max_q;
`ifdef CLE_READER_CRC_EN
  assign crc       = crc_q;
`endif

endmodule

// File: doc/cle_label_reader.md
Name: cle_label_reader

Overview:
- Read-back engine for the component labeling flow: after the labeling engine asserts finish, it scans the 1024x8 label SRAM in raster order.
- Re-packs the label map into a 1-bit-per-pixel mask, in the same 128x8 byte format as the input image ROM.
- Streams the mask bytes out over a valid/ready port and accumulates summary statistics: foreground pixel count and maximum label.
- Used for self-check (mask must equal the source image) and for host dump.

Parameters:
- BASE_ADDR, 0, first SRAM word read (10-bit).
- NBYTES, 128, number of packed output bytes; NBYTES*8 SRAM words are read.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- sram_q  input  8  SRAM read data; valid the cycle after sram_a is presented.
- sram_a  output  10  SRAM address.
- sram_wen  output  1  SRAM write enable, active-low; constant 1 (read only).
- out_data  output  8  packed mask byte; bit7 = lowest address (leftmost pixel).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the last byte handshake.
- fg_count  output  11  number of nonzero labels read (0..1024).
- max_label  output  8  largest label value read.

Behaviour:
- Reset: state=IDLE; sram_a=BASE_ADDR; sram_wen=1; out_data=0; out_valid=0; busy=0; done=0; fg_count=0; max_label=0.
- Reset mid-scan aborts immediately; no further SRAM reads and no output.
- States: IDLE, FETCH, LAST, EMIT, DONE.
- IDLE & start:
  - clear fg_count, max_label and the byte counter.
  - sram_a=BASE_ADDR; go to FETCH; busy=1.
- FETCH (8 cycles per byte):
  - sram_a increments each cycle (addresses k*8 .. k*8+7 relative to BASE_ADDR).
  - sram_q from the previous cycle is shifted into the shift register as bit (sram_q!=0).
  - Leave FETCH after the 8th address; go to LAST.
- LAST: captures the 8th sram_q; out_data=shift result; out_valid=1; go to EMIT.
- EMIT:
  - hold out_data/out_valid stable until out_ready.
  - On handshake: out_valid=0. If byte counter==NBYTES-1, go to DONE; else increment counter and return to FETCH.
  - sram_a already points at the next byte's first word.
- DONE: done=1 for exactly one cycle; busy=0; go to IDLE. Statistics hold until the next start.
- Statistics: per captured word, fg_count += (sram_q!=0); max_label = max(max_label, sram_q).
- sram_a wraps modulo 1024 (BASE_ADDR+1023 -> 0).
- start while busy: ignored.
- out_ready high when out_valid is low: no effect.
- Latency with out_ready tied high:
  - first out_valid 10 cycles after start.
  - each byte takes 10 cycles.
  - done asserts 1281 cycles after start (NBYTES=128).

Optional Feature:
- Macro: CLE_READER_CRC_EN.
- When defined:
  - adds output port crc (8 bits).
  - CRC-8, polynomial 0x07, init 0x00, MSB-first, computed over every raw 8-bit label read in address order.
  - cleared on start; final value valid when done pulses.
- When undefined: port and logic are absent; all other behaviour identical.

Test Plan:
- All-zero SRAM, out_ready=1, start → 128 bytes of 0x00; fg_count=0; max_label=0; done at cycle 1281 after start.
- SRAM word i = (i%8==0)?8'h05:0 → every byte 0x80; fg_count=128; max_label=0x05.
- Checkerboard pattern; out_ready low for 5 cycles at byte 3 → out_data and out_valid held stable while stalled; byte count is still 128; no sram_a advance during EMIT.
- Labels 1..4 in four 8x8 blocks, one word = 0xFE → mask matches the source bitmap; max_label=0xFE; fg_count=257.
- Reset asserted at byte 40 mid-FETCH, then a new start → all outputs at reset values immediately; second scan is complete and correct.
- CLE_READER_CRC_EN: all SRAM = 0x01 → crc equals the reference CRC-8 of 1024 bytes of 0x01 (computed by the bench model); all-zero SRAM → crc=0x00.
